// File: rtl/execute_mc_stage.sv
// rtl/execute_mc_stage.sv - LEGv8 EX stage with EX/MEM register and iterative shift-add MUL
module execute_mc_stage #(
    parameter int N            = 64,
    parameter int BRANCH_SHIFT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         stall_E,
    output logic         valid_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         zero_M
);

    localparam int            SW   = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] count_q, count_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  pcb_l_q, pcb_l_d;
    logic [N-1:0]  wd_l_q, wd_l_d;
    logic          valid_m_q, valid_m_d;
    logic [N-1:0]  alu_m_q, alu_m_d;
    logic [N-1:0]  wd_m_q, wd_m_d;
    logic [N-1:0]  pcb_m_q, pcb_m_d;
    logic          zero_m_q, zero_m_d;
    logic          stall;

    logic [N-1:0]  b_op;
    logic [N-1:0]  alu_res;
    logic [N-1:0]  pc_branch;
    logic [N-1:0]  mul_acc;

    always_comb begin
        b_op    = AluSrc ? signImm_E : readData2_E;
        alu_res = '0;
        case (AluControl)
            OP_AND:  alu_res = readData1_E & b_op;
            OP_OR:   alu_res = readData1_E | b_op;
            OP_ADD:  alu_res = readData1_E + b_op;
            OP_SUB:  alu_res = readData1_E - b_op;
            OP_PASS: alu_res = b_op;
            OP_NOR:  alu_res = ~(readData1_E | b_op);
            OP_LSL:  alu_res = readData1_E << b_op[SW-1:0];
            OP_LSR:  alu_res = readData1_E >> b_op[SW-1:0];
            default: alu_res = '0;
        endcase
        pc_branch = PC_E + (signImm_E << BRANCH_SHIFT);
        mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        pcb_l_d   = pcb_l_q;
        wd_l_d    = wd_l_q;
        valid_m_d = 1'b0;
        alu_m_d   = alu_m_q;
        wd_m_d    = wd_m_q;
        pcb_m_d   = pcb_m_q;
        zero_m_d  = zero_m_q;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_E && !flush_E) begin
                    if (AluControl == OP_MUL) begin
                        // The branch target is latched pre-summed; MEM sees it only at completion.
                        mcand_d  = readData1_E;
                        mplier_d = b_op;
                        acc_d    = '0;
                        count_d  = '0;
                        pcb_l_d  = pc_branch;
                        wd_l_d   = readData2_E;
                        state_d  = BUSY;
                        stall    = 1'b1;
                    end else begin
                        alu_m_d   = alu_res;
                        zero_m_d  = (alu_res == '0);
                        pcb_m_d   = pc_branch;
                        wd_m_d    = readData2_E;
                        valid_m_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush_E) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = mul_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    if (count_q == LAST) begin
                        alu_m_d   = mul_acc;
                        zero_m_d  = (mul_acc == '0);
                        pcb_m_d   = pcb_l_q;
                        wd_m_d    = wd_l_q;
                        valid_m_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            pcb_l_q   <= '0;
            wd_l_q    <= '0;
            valid_m_q <= 1'b0;
            alu_m_q   <= '0;
            wd_m_q    <= '0;
            pcb_m_q   <= '0;
            zero_m_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            pcb_l_q   <= pcb_l_d;
            wd_l_q    <= wd_l_d;
            valid_m_q <= valid_m_d;
            alu_m_q   <= alu_m_d;
            wd_m_q    <= wd_m_d;
            pcb_m_q   <= pcb_m_d;
            zero_m_q  <= zero_m_d;
        end
    end

    assign stall_E     = stall;
    assign valid_M     = valid_m_q;
    assign aluResult_M = alu_m_q;
    assign writeData_M = wd_m_q;
    assign PCBranch_M  = pcb_m_q;
    assign zero_M      = zero_m_q;

endmodule
